// File: rtl/rca_pipe_n.sv
// rca_pipe_n: pipelined W-bit ripple-carry adder/subtractor.
//
// The operands are split into STAGES equal chunks of C = W/STAGES bits. Stage k adds chunk k
// using the carry registered by stage k-1. Upper operand chunks travel forward with the op.
// Finished low result chunks also travel forward, so all W result bits leave together.
// The whole pipe stalls as one unit when the output holds a result the consumer does not take.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_in_valid   operand set i_a/i_b/i_ci/i_sub presented
//   o_in_ready   operands accepted this cycle when i_in_valid is set
//   i_a, i_b     W-bit operands
//   i_ci         carry-in (add only)
//   i_sub        0: a + b + ci, 1: a - b
//   o_out_valid  o_s/o_co/o_ovf hold a result
//   i_out_ready  consumer takes the result this cycle
//   o_s          W-bit sum/difference
//   o_co         carry-out (add) / no-borrow (sub)
//   o_ovf        signed overflow
module rca_pipe_n #(
    parameter int unsigned W      = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_ci,
    input  logic         i_sub,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_s,
    output logic         o_co,
    output logic         o_ovf
);

    localparam int unsigned SDIV = (STAGES == 0) ? 1 : STAGES;
    localparam int unsigned C    = W / SDIV;

    if (W < 1 || STAGES < 1 || STAGES > W || (W % SDIV) != 0) begin : g_param_check
        $error("rca_pipe_n: W must be a multiple of STAGES with 1 <= STAGES <= W");
    end

    logic              w_advance;
    logic [W-1:0]      w_b_eff;
    logic              w_c0;

    // Pipeline registers, index k = output of stage k.
    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_cy;
    logic [W-1:0]      r_a [STAGES];
    logic [W-1:0]      r_b [STAGES];
    logic [W-1:0]      r_s [STAGES];
    logic              r_ovf;

    // Stage inputs and next-state values.
    logic [STAGES-1:0] w_v_in;
    logic [STAGES-1:0] w_c_in;
    logic [STAGES-1:0] w_c_nx;
    logic [W-1:0]      w_a_in [STAGES];
    logic [W-1:0]      w_b_in [STAGES];
    logic [W-1:0]      w_s_in [STAGES];
    logic [W-1:0]      w_s_nx [STAGES];
    logic [C:0]        w_sum  [STAGES];
    logic              w_ovf_nx;

    // Nothing moves unless the output slot is empty or being drained.
    assign w_advance  = !o_out_valid || i_out_ready;
    assign o_in_ready = w_advance;

    // Subtraction is a + ~b + 1; ci is ignored in that case.
    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign w_c0    = i_sub | i_ci;

    always_comb begin
        w_v_in    = '0;
        w_c_in    = '0;
        w_a_in[0] = i_a;
        w_b_in[0] = w_b_eff;
        w_s_in[0] = '0;
        w_c_in[0] = w_c0;
        w_v_in[0] = i_in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_s_in[k] = r_s[k-1];
            w_c_in[k] = r_cy[k-1];
            w_v_in[k] = r_vld[k-1];
        end
    end

    always_comb begin
        w_c_nx = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_sum[k]  = {1'b0, w_a_in[k][k*C +: C]} + {1'b0, w_b_in[k][k*C +: C]}
                      + {{C{1'b0}}, w_c_in[k]};
            w_s_nx[k] = w_s_in[k];
            w_s_nx[k][k*C +: C] = w_sum[k][C-1:0];
            w_c_nx[k] = w_sum[k][C];
        end
        // The last stage sees the full result, so overflow is resolved there.
        w_ovf_nx = (w_a_in[STAGES-1][W-1] == w_b_in[STAGES-1][W-1])
                && (w_s_nx[STAGES-1][W-1] != w_a_in[STAGES-1][W-1]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
            r_cy  <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (w_advance) begin
            r_vld <= w_v_in;
            // Data only loads behind a valid bit; bubbles leave old contents in place.
            for (int k = 0; k < STAGES; k++) begin
                if (w_v_in[k]) begin
                    r_a[k]  <= w_a_in[k];
                    r_b[k]  <= w_b_in[k];
                    r_s[k]  <= w_s_nx[k];
                    r_cy[k] <= w_c_nx[k];
                end
            end
            if (w_v_in[STAGES-1]) begin
                r_ovf <= w_ovf_nx;
            end
        end
    end

    assign o_out_valid = r_vld[STAGES-1];
    assign o_s         = r_s[STAGES-1];
    assign o_co        = r_cy[STAGES-1];
    assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_rca_pipe_n.sv
// Bench for rca_pipe_n: a 16-bit/4-stage instance and a 4-bit/1-stage instance share a clock.
// Expected results come from integer arithmetic; each queued op carries the tick at which it
// should reach the output, pushed back by one for every stall cycle.
module tb_rca_pipe_n;

    localparam int S16 = 4;
    localparam int S4  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v16, rdy16, ov16, ordy16, ci16, sub16, co16, ovf16;
    logic [15:0] a16, b16, s16;
    logic        v4, rdy4, ov4, ordy4, ci4, sub4, co4, ovf4;
    logic [3:0]  a4, b4, s4;

    rca_pipe_n #(.W(16), .STAGES(S16)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(v16), .o_in_ready(rdy16), .i_a(a16), .i_b(b16),
        .i_ci(ci16), .i_sub(sub16), .o_out_valid(ov16), .i_out_ready(ordy16), .o_s(s16),
        .o_co(co16), .o_ovf(ovf16)
    );

    rca_pipe_n #(.W(4), .STAGES(S4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(v4), .o_in_ready(rdy4), .i_a(a4), .i_b(b4),
        .i_ci(ci4), .i_sub(sub4), .o_out_valid(ov4), .i_out_ready(ordy4), .o_s(s4),
        .o_co(co4), .o_ovf(ovf4)
    );

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ovf;
        int          rdy;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];
    int   tick_n = 0;
    int   checks = 0;
    int   errors = 0;
    logic acc16;
    int   n_acc;
    bit   stalled;

    function automatic exp_t model(input int w, input int a, input int b, input logic ci,
                                   input logic sub, input int rdy);
        exp_t e;
        int mask = (1 << w) - 1;
        int half = 1 << (w - 1);
        int bp   = sub ? (~b & mask) : (b & mask);
        int cin  = sub ? 1 : (ci ? 1 : 0);
        int tot  = (a & mask) + bp + cin;
        int sa   = ((a & mask) >= half) ? (a & mask) - (1 << w) : (a & mask);
        int sb   = (bp >= half) ? bp - (1 << w) : bp;
        int r    = sa + sb + cin;
        e.s   = 16'(tot & mask);
        e.co  = ((tot >> w) & 1) != 0;
        e.ovf = (r >= half) || (r < -half);
        e.rdy = rdy;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check both DUTs at the negedge against the queues, then update the queues
    // with whatever transfers the next rising edge will perform.
    task automatic tick();
        logic ev;
        @(negedge clk);
        ev = (q16.size() > 0) && (q16[0].rdy <= tick_n);
        chk("out_valid16", {31'b0, ov16}, {31'b0, ev});
        chk("in_ready16", {31'b0, rdy16}, {31'b0, !ev || ordy16});
        if (ev) begin
            chk("s16", {16'b0, s16}, {16'b0, q16[0].s});
            chk("co16", {31'b0, co16}, {31'b0, q16[0].co});
            chk("ovf16", {31'b0, ovf16}, {31'b0, q16[0].ovf});
        end
        acc16 = 1'b0;
        if (ev && ordy16) begin
            void'(q16.pop_front());
        end else if (ev) begin
            foreach (q16[i]) if (q16[i].rdy > tick_n) q16[i].rdy++;
        end
        if (rst) begin
            q16.delete();
        end else if (v16 && (!ev || ordy16)) begin
            q16.push_back(model(16, int'(a16), int'(b16), ci16, sub16, tick_n + S16));
            acc16 = 1'b1;
        end

        ev = (q4.size() > 0) && (q4[0].rdy <= tick_n);
        chk("out_valid4", {31'b0, ov4}, {31'b0, ev});
        chk("in_ready4", {31'b0, rdy4}, {31'b0, !ev || ordy4});
        if (ev) begin
            chk("s4", {28'b0, s4}, {16'b0, q4[0].s});
            chk("co4", {31'b0, co4}, {31'b0, q4[0].co});
            chk("ovf4", {31'b0, ovf4}, {31'b0, q4[0].ovf});
        end
        if (ev && ordy4) begin
            void'(q4.pop_front());
        end else if (ev) begin
            foreach (q4[i]) if (q4[i].rdy > tick_n) q4[i].rdy++;
        end
        if (rst) begin
            q4.delete();
        end else if (v4 && (!ev || ordy4)) begin
            q4.push_back(model(4, int'(a4), int'(b4), ci4, sub4, tick_n + S4));
        end

        tick_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic sub, input logic [15:0] es,
                            input logic eco, input logic eovf);
        a16 = a; b16 = b; ci16 = ci; sub16 = sub; v16 = 1'b1;
        tick();
        v16 = 1'b0;
        repeat (S16 - 1) tick();
        chk({tag, "_valid"}, {31'b0, ov16}, 32'd1);
        chk({tag, "_s"}, {16'b0, s16}, {16'b0, es});
        chk({tag, "_co"}, {31'b0, co16}, {31'b0, eco});
        chk({tag, "_ovf"}, {31'b0, ovf16}, {31'b0, eovf});
    endtask

    task automatic reset_zero_checks(input string tag);
        chk({tag, "_valid16"}, {31'b0, ov16}, 32'd0);
        chk({tag, "_s16"}, {16'b0, s16}, 32'd0);
        chk({tag, "_co16"}, {31'b0, co16}, 32'd0);
        chk({tag, "_ovf16"}, {31'b0, ovf16}, 32'd0);
        chk({tag, "_in_ready16"}, {31'b0, rdy16}, 32'd1);
        chk({tag, "_valid4"}, {31'b0, ov4}, 32'd0);
        chk({tag, "_s4"}, {28'b0, s4}, 32'd0);
        chk({tag, "_co4"}, {31'b0, co4}, 32'd0);
        chk({tag, "_ovf4"}, {31'b0, ovf4}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        v16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; sub16 = 1'b0; ordy16 = 1'b1;
        v4  = 1'b0; a4  = '0; b4  = '0; ci4  = 1'b0; sub4  = 1'b0; ordy4  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_zero_checks("reset");

        // Exhaustive 4-bit adds through the single-stage instance.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    a4 = 4'(a); b4 = 4'(b); ci4 = c[0]; sub4 = 1'b0; v4 = 1'b1;
                    tick();
                end
            end
        end
        v4 = 1'b0;
        repeat (2) tick();

        // Wrap-around and signed overflow corners.
        directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        repeat (2) tick();

        // Back-to-back random stream with a 3-cycle consumer stall in the middle.
        n_acc = 0;
        stalled = 1'b0;
        for (int it = 0; it < 40 && n_acc < 10; it++) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            ci16 = 1'($urandom); sub16 = 1'($urandom); v16 = 1'b1;
            if (n_acc == 5 && !stalled) begin
                stalled = 1'b1;
                ordy16 = 1'b0;
                repeat (3) begin
                    #1;
                    chk("stall_in_ready", {31'b0, rdy16}, 32'd0);
                    tick();
                end
                ordy16 = 1'b1;
            end
            tick();
            if (acc16) n_acc++;
        end
        v16 = 1'b0;
        repeat (S16 + 2) tick();

        // Alternating bubbles, random ops and both modes on the 4-bit instance too.
        for (int i = 0; i < 12; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            ci16 = 1'($urandom); sub16 = 1'($urandom); v16 = (i % 2 == 0);
            a4 = 4'($urandom); b4 = 4'($urandom);
            ci4 = 1'($urandom); sub4 = 1'($urandom); v4 = (i % 3 != 0);
            tick();
        end
        v16 = 1'b0; v4 = 1'b0;
        repeat (S16 + 1) tick();

        // Reset with three ops in flight; none of them may surface afterwards.
        for (int i = 0; i < 3; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            ci16 = 1'($urandom); sub16 = 1'($urandom); v16 = 1'b1;
            tick();
        end
        v16 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reset_zero_checks("midreset");
        repeat (S16 + 2) tick();
        directed("post_reset", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
